// File: rtl/wash_sequencer_if.sv
// Handshake bundle between the billing/panel side and the wash program sequencer.
interface wash_sequencer_if;
    logic        start;
    logic [1:0]  mode;
    logic        p_pos;
    logic        a_pos;
    logic [11:0] remain;
    logic [3:0]  phase_light;
    logic        busy;
    logic        paused;
    logic        done;
    logic        aborted;

    modport master (
        output start, mode, p_pos, a_pos,
        input  remain, phase_light, busy, paused, done, aborted
    );

    modport slave (
        input  start, mode, p_pos, a_pos,
        output remain, phase_light, busy, paused, done, aborted
    );
endinterface

// File: rtl/wash_sequencer.sv
// Wash program sequencer: fill/wash/rinse/spin countdown with BCD remaining time.
// Optional pause/abort support is enabled by defining WASH_PAUSE_EN.
module wash_sequencer #(
    parameter int TICK = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    wash_sequencer_if.slave  bus
);
    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WASH, S_RINSE, S_SPIN, S_DONE, S_PAUSE
    } state_t;

    state_t          r_state;
    logic [1:0]      r_mode;
    logic [TW-1:0]   r_tick;
    logic [6:0]      r_phase_cnt;
    logic [11:0]     r_remain;
    logic [3:0]      r_light;
    logic            r_busy;
    logic            r_done;
    logic            r_start_q;
    logic            r_start_qq;

    logic            w_start_rise;
    logic            w_tick;
    state_t          w_first;
    state_t          w_run_ns;
    logic [6:0]      w_run_cnt;

    function automatic logic [6:0] dur(input logic [1:0] m, input state_t s);
        case (s)
            S_FILL:  case (m) 2'd0: dur = 7'd0;  2'd1: dur = 7'd10; 2'd2: dur = 7'd15; default: dur = 7'd20; endcase
            S_WASH:  case (m) 2'd0: dur = 7'd0;  2'd1: dur = 7'd30; 2'd2: dur = 7'd45; default: dur = 7'd60; endcase
            S_RINSE: case (m) 2'd0: dur = 7'd0;  2'd1: dur = 7'd20; 2'd2: dur = 7'd30; default: dur = 7'd40; endcase
            S_SPIN:  case (m) 2'd0: dur = 7'd20; 2'd1: dur = 7'd20; 2'd2: dur = 7'd30; default: dur = 7'd40; endcase
            default: dur = 7'd0;
        endcase
    endfunction

    function automatic logic [11:0] total_bcd(input logic [1:0] m);
        case (m)
            2'd0:    total_bcd = 12'h020;
            2'd1:    total_bcd = 12'h080;
            2'd2:    total_bcd = 12'h120;
            default: total_bcd = 12'h160;
        endcase
    endfunction

    // First phase at or after s whose duration is nonzero; DONE when none remain.
    function automatic state_t first_from(input logic [1:0] m, input state_t s);
        if (s == S_FILL && dur(m, S_FILL) != 7'd0) return S_FILL;
        if ((s inside {S_FILL, S_WASH}) && dur(m, S_WASH) != 7'd0) return S_WASH;
        if ((s inside {S_FILL, S_WASH, S_RINSE}) && dur(m, S_RINSE) != 7'd0) return S_RINSE;
        if (s != S_DONE && dur(m, S_SPIN) != 7'd0) return S_SPIN;
        return S_DONE;
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            S_FILL:  succ = S_WASH;
            S_WASH:  succ = S_RINSE;
            S_RINSE: succ = S_SPIN;
            default: succ = S_DONE;
        endcase
    endfunction

    function automatic logic [3:0] light(input state_t s);
        case (s)
            S_FILL:  light = 4'b1000;
            S_WASH:  light = 4'b0100;
            S_RINSE: light = 4'b0010;
            S_SPIN:  light = 4'b0001;
            default: light = 4'b0000;
        endcase
    endfunction

    // Saturating BCD decrement with digit borrows.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h, t, u;
        h = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (v == 12'h000) return 12'h000;
        if (u != 4'd0) u = u - 4'd1;
        else begin
            u = 4'd9;
            if (t != 4'd0) t = t - 4'd1;
            else begin
                t = 4'd9;
                h = h - 4'd1;
            end
        end
        return {h, t, u};
    endfunction

    always_comb begin
        w_start_rise = r_start_q & ~r_start_qq;
        w_tick       = (r_tick == TW'(TICK - 1));
        w_first      = first_from(bus.mode, S_FILL);
        w_run_ns     = r_state;
        w_run_cnt    = r_phase_cnt - 7'd1;
        if (r_phase_cnt <= 7'd1) begin
            w_run_ns  = first_from(r_mode, succ(r_state));
            w_run_cnt = dur(r_mode, first_from(r_mode, succ(r_state)));
        end
    end

`ifdef WASH_PAUSE_EN
    state_t r_saved;
    logic   r_paused;
    logic   r_aborted;
`else
    wire    w_unused = bus.p_pos ^ bus.a_pos;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_tick      <= '0;
            r_phase_cnt <= 7'd0;
            r_remain    <= 12'h000;
            r_light     <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_q   <= 1'b0;
            r_start_qq  <= 1'b0;
`ifdef WASH_PAUSE_EN
            r_saved     <= S_IDLE;
            r_paused    <= 1'b0;
            r_aborted   <= 1'b0;
`endif
        end else begin
            r_start_q  <= bus.start;
            r_start_qq <= r_start_q;
            r_done     <= 1'b0;
`ifdef WASH_PAUSE_EN
            r_aborted  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_mode      <= bus.mode;
                        r_remain    <= total_bcd(bus.mode);
                        r_state     <= w_first;
                        r_phase_cnt <= dur(bus.mode, w_first);
                        r_light     <= light(w_first);
                        r_tick      <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                    if (w_tick) begin
                        r_tick      <= '0;
                        r_remain    <= bcd_dec(r_remain);
                        r_phase_cnt <= w_run_cnt;
                        if (w_run_ns == S_DONE) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_light <= 4'b0000;
                        end else begin
                            r_state <= w_run_ns;
                            r_light <= light(w_run_ns);
`ifdef WASH_PAUSE_EN
                            if (bus.p_pos) begin
                                r_state  <= S_PAUSE;
                                r_saved  <= w_run_ns;
                                r_paused <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
`ifdef WASH_PAUSE_EN
                        if (bus.p_pos) begin
                            r_tick   <= r_tick;
                            r_state  <= S_PAUSE;
                            r_saved  <= r_state;
                            r_paused <= 1'b1;
                        end
`endif
                    end
                end
`ifdef WASH_PAUSE_EN
                S_PAUSE: begin
                    if (bus.a_pos) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_paused  <= 1'b0;
                        r_remain  <= 12'h000;
                        r_light   <= 4'b0000;
                    end else if (bus.p_pos) begin
                        r_state  <= r_saved;
                        r_paused <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.remain      = r_remain;
    assign bus.phase_light = r_light;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
`ifdef WASH_PAUSE_EN
    assign bus.paused      = r_paused;
    assign bus.aborted     = r_aborted;
`else
    assign bus.paused      = 1'b0;
    assign bus.aborted     = 1'b0;
`endif
endmodule
